shift_right_seq: RTL

//  Multicycle right shifter for SRL/SRA/SRLV/SRAV in the MIPS execute stage; complements the combinational left-shift path.

---
 rtl/shift_right_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/shift_right_seq.sv
// Multicycle right shifter (SRL/SRA) with Start/Busy/Done handshake; one bit per clock.
// Optional macro SHR_FAST4_EN: shift by 4 per clock while at least 4 positions remain.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   In,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   w_work_nxt;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   w_out_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic [SHAMT_W-1:0] r_count;
  logic [SHAMT_W-1:0] w_count_nxt;
  logic [SHAMT_W-1:0] w_count_dec;
  logic               r_fill;
  logic               w_fill_nxt;
  logic               r_busy;
  logic               r_done;

  // One shift step of the working register and the matching count decrement
  always_comb begin
    w_shifted   = {r_fill, r_work[WIDTH-1:1]};
    w_count_dec = r_count - SHAMT_W'(1);
`ifdef SHR_FAST4_EN
    if (r_count >= SHAMT_W'(4)) begin
      w_shifted   = {{4{r_fill}}, r_work[WIDTH-1:4]};
      w_count_dec = r_count - SHAMT_W'(4);
    end else begin
      w_shifted   = {r_fill, r_work[WIDTH-1:1]};
      w_count_dec = r_count - SHAMT_W'(1);
    end
`endif
  end

  // Next-state and datapath decode; Start is only honoured outside SHIFT
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_count_nxt = r_count;
    w_fill_nxt  = r_fill;
    w_out_nxt   = r_out;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          w_work_nxt  = In;
          w_count_nxt = Shamt;
          w_fill_nxt  = Arith & In[WIDTH-1];
          if (Shamt == '0) begin
            w_out_nxt   = In;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_work_nxt  = w_shifted;
        w_count_nxt = w_count_dec;
        if (w_count_dec == '0) begin
          w_out_nxt   = w_shifted;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; Busy/Done registered from the next state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_count <= '0;
      r_fill  <= 1'b0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_count <= w_count_nxt;
      r_fill  <= w_fill_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= (w_state_nxt == ST_SHIFT);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign Out  = r_out;

endmodule
